// File: rtl/instr_fetch_pkg.sv
// Shared widths, fetch FSM encodings and PC helpers for the fetch front-end.
// Decode and debug logic import the same encodings to interpret fetch state.
package instr_fetch_pkg;

    localparam int ADDR_SIZE      = 8;
    localparam int WORD_SIZE      = 16;
    localparam int IF_INSTR_BYTES = 2;

    localparam logic [1:0] IF_IDLE = 2'd0;
    localparam logic [1:0] IF_RUN  = 2'd1;
    localparam logic [1:0] IF_HALT = 2'd2;

    // Instructions are word aligned, so redirect targets drop bit 0.
    function automatic logic [ADDR_SIZE-1:0] align_pc(input logic [ADDR_SIZE-1:0] addr);
        return {addr[ADDR_SIZE-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: aligned load, fixed-step increment, modular wrap.
// Kept standalone so a later branch unit can reuse it.
module if_pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_SIZE-1:0] RESET_PC    = '0,
    parameter int                   INSTR_BYTES = IF_INSTR_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ADDR_SIZE-1:0] target,
    input  logic                 inc,
    output logic [ADDR_SIZE-1:0] pc
);

    localparam logic [ADDR_SIZE-1:0] STEP = ADDR_SIZE'(INSTR_BYTES);

    // Load has priority over increment; the add simply wraps at the top of the address space.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= align_pc(target);
        end else if (inc) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front-end: owns the PC, captures the ROM word into the IR and
// hands it to decode over a valid/ready handshake.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_SIZE-1:0] RESET_PC    = '0,
    parameter int                   INSTR_BYTES = IF_INSTR_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 pc_load,
    input  logic [ADDR_SIZE-1:0] pc_target,
    output logic [ADDR_SIZE-1:0] rom_addr,
    input  logic [WORD_SIZE-1:0] rom_data,
    output logic [WORD_SIZE-1:0] ir,
    output logic [ADDR_SIZE-1:0] ir_pc,
    output logic                 ir_valid,
    input  logic                 ir_ready,
    output logic                 halted
);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [ADDR_SIZE-1:0] pc;
    logic                 fetch;
    logic                 flush;

    // A redirect or halt request suppresses fetching; otherwise fetch whenever the IR slot frees up.
    assign flush    = pc_load && (state != IF_IDLE);
    assign fetch    = (state == IF_RUN) && !pc_load && !halt_req && (!ir_valid || ir_ready);
    assign rom_addr = pc;
    assign halted   = (state == IF_HALT);

    if_pc_reg #(
        .RESET_PC    (RESET_PC),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (pc_load),
        .target (pc_target),
        .inc    (fetch),
        .pc     (pc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IF_IDLE: if (start)    state_nxt = IF_RUN;
            IF_RUN:  if (pc_load)  state_nxt = IF_RUN;
                     else if (halt_req) state_nxt = IF_HALT;
            IF_HALT: if (pc_load)  state_nxt = IF_RUN;
            default:               state_nxt = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IF_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A valid IR is never overwritten; it only leaves by being accepted or flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (flush) begin
            ir_valid <= 1'b0;
        end else if (fetch) begin
            ir       <= rom_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
        end else if (ir_ready) begin
            ir_valid <= 1'b0;
        end
    end

endmodule
